// File: rtl/dieroll_pkg.sv
// Shared types and constants for the die-roll serial reporting path.
// Also holds the face-to-decimal conversion used at request accept.
package dieroll_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_SEND,
        SEQ_DONE
    } seq_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam int         FRAME_BYTES = 4;

    typedef struct packed {
        logic [1:0] tens;
        logic [3:0] ones;
    } digits_t;

    // Face never exceeds 32, so a comparator chain replaces a divider.
    function automatic digits_t to_digits(input logic [5:0] face);
        digits_t d;
        d = '0;
        if (face >= 6'd30) begin
            d.tens = 2'd3;
            d.ones = 4'(face - 6'd30);
        end else if (face >= 6'd20) begin
            d.tens = 2'd2;
            d.ones = 4'(face - 6'd20);
        end else if (face >= 6'd10) begin
            d.tens = 2'd1;
            d.ones = 4'(face - 6'd10);
        end else begin
            d.tens = 2'd0;
            d.ones = 4'(face);
        end
        return d;
    endfunction

endpackage

// File: rtl/dieroll_uart_tx_if.sv
// Request/status handshake between the roll source and the serial reporter.
interface dieroll_uart_tx_if;

    logic       i_valid;
    logic [4:0] i_dieRoll;
    logic       o_ready;
    logic       o_done;

    modport master (
        output i_valid,
        output i_dieRoll,
        input  o_ready,
        input  o_done
    );

    modport slave (
        input  i_valid,
        input  i_dieRoll,
        output o_ready,
        output o_done
    );

endinterface

// File: rtl/uart_tx_byte.sv
// Generic 8N1 byte serializer with registered line output.
// A start request in the final stop-bit cycle chains the next byte with no gap.
//
// state | meaning
// IDLE  | line high, waiting for start_i
// START | driving the start bit (0)
// DATA  | driving data bits, LSB first
// STOP  | driving the stop bit (1); done_o on its last cycle
module uart_tx_byte
    import dieroll_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    assign bit_end = (baud_q == BAUD_LAST);
    assign tx_o    = tx_q;
    assign busy_o  = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        done_o  = 1'b0;

        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = START;
                    shift_d = byte_i;
                    baud_d  = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    done_o = 1'b1;
                    if (start_i) begin
                        state_d = START;
                        shift_d = byte_i;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the state being entered, so tx_q lines up with state_q.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/dieroll_uart_tx.sv
// Reports each accepted die roll as "<tens><ones>\r\n" over UART 8N1.
//
// state    | meaning
// SEQ_IDLE | o_ready high, waiting for i_valid
// SEQ_SEND | serializer busy on frame byte idx_q
// SEQ_DONE | one-cycle o_done after the last stop bit
module dieroll_uart_tx
    import dieroll_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    dieroll_uart_tx_if.slave    bus,
    output logic                o_tx
);

    seq_t       seq_q, seq_d;
    logic [1:0] idx_q, idx_d;
    digits_t    dig_q, dig_d;
    digits_t    dig_in;
    logic [5:0] face;
    logic       accept;
    logic       ser_start;
    logic [7:0] ser_byte;
    logic       ser_busy;
    logic       ser_done;

    function automatic logic [7:0] frame_byte(input logic [1:0] idx, input digits_t d);
        logic [7:0] b;
        b = ASCII_LF;
        case (idx)
            2'd0:    b = ASCII_ZERO + {6'd0, d.tens};
            2'd1:    b = ASCII_ZERO + {4'd0, d.ones};
            2'd2:    b = ASCII_CR;
            default: b = ASCII_LF;
        endcase
        return b;
    endfunction

    assign face        = {1'b0, bus.i_dieRoll} + 6'd1;
    assign dig_in      = to_digits(face);
    assign bus.o_ready = (seq_q == SEQ_IDLE) && !ser_busy;
    assign bus.o_done  = (seq_q == SEQ_DONE);
    assign accept      = bus.o_ready && bus.i_valid;

    always_comb begin
        seq_d     = seq_q;
        idx_d     = idx_q;
        dig_d     = dig_q;
        ser_start = 1'b0;
        ser_byte  = frame_byte(2'd0, dig_in);

        case (seq_q)
            SEQ_IDLE: begin
                if (accept) begin
                    seq_d     = SEQ_SEND;
                    idx_d     = '0;
                    dig_d     = dig_in;
                    ser_start = 1'b1;
                end
            end
            SEQ_SEND: begin
                // Next byte is offered during the stop bit so it chains without a gap.
                ser_byte = frame_byte(idx_q + 2'd1, dig_q);
                if (ser_done) begin
                    if (idx_q == 2'(FRAME_BYTES - 1)) begin
                        seq_d = SEQ_DONE;
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        ser_start = 1'b1;
                    end
                end
            end
            SEQ_DONE: seq_d = SEQ_IDLE;
            default:  seq_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            seq_q <= SEQ_IDLE;
            idx_q <= '0;
            dig_q <= '0;
        end else begin
            seq_q <= seq_d;
            idx_q <= idx_d;
            dig_q <= dig_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .start_i   (ser_start),
        .byte_i    (ser_byte),
        .tx_o      (o_tx),
        .busy_o    (ser_busy),
        .done_o    (ser_done)
    );

endmodule

// File: tb/tb_dieroll_uart_tx.sv
// Randomized bench for dieroll_uart_tx against a frame-level reference model
// and a mid-bit UART receiver.
module tb_dieroll_uart_tx;

    localparam int CPB       = 4;
    localparam int FRAME_CYC = 40 * CPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tx;

    dieroll_uart_tx_if bus();

    dieroll_uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus),
        .o_tx      (tx)
    );

    initial forever #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    int free_at  = 0;
    int done_at  = -1;
    int n_acc    = 0;
    int last_acc = 0;
    logic [7:0] exp_q[$];
    int         exp_start_q[$];

    logic       mon_act = 1'b0;
    int         mon_cnt = 0;
    int         mon_idx = 0;
    int         mon_t0  = 0;
    logic [7:0] mon_sh  = 8'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic void push_frame(input logic [4:0] roll);
        int face;
        face = int'(roll) + 1;
        exp_q.push_back(8'(48 + face / 10));
        exp_q.push_back(8'(48 + face % 10));
        exp_q.push_back(8'd13);
        exp_q.push_back(8'd10);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Model, checker and UART receiver, all evaluated mid-cycle.
    initial begin : model
        int b;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                free_at = 0;
                done_at = -1;
                exp_q.delete();
                exp_start_q.delete();
                mon_act = 1'b0;
                mon_idx = 0;
            end else begin
                chk("ready", {31'd0, bus.o_ready}, {31'd0, cyc >= free_at});
                chk("done", {31'd0, bus.o_done}, {31'd0, cyc == done_at});

                if (mon_act) begin
                    mon_cnt++;
                    if (mon_cnt >= CPB / 2 && (mon_cnt - CPB / 2) % CPB == 0) begin
                        b = (mon_cnt - CPB / 2) / CPB;
                        if (b == 0) begin
                            chk("start_bit", {31'd0, tx}, 32'd0);
                        end else if (b <= 8) begin
                            mon_sh = {tx, mon_sh[7:1]};
                        end else begin
                            chk("stop_bit", {31'd0, tx}, 32'd1);
                            if (exp_q.size() > 0)
                                chk("rx_byte", {24'd0, mon_sh}, {24'd0, exp_q.pop_front()});
                            else
                                chk("rx_byte_unexpected", {24'd0, mon_sh}, 32'h1FF);
                            mon_act = 1'b0;
                            mon_idx = (mon_idx + 1) % 4;
                        end
                    end
                end else if (tx == 1'b0) begin
                    mon_act = 1'b1;
                    mon_cnt = 0;
                    if (mon_idx == 0) begin
                        if (exp_start_q.size() > 0)
                            chk("frame_start", cyc, exp_start_q.pop_front());
                        else
                            chk("frame_start_unexpected", cyc, 32'hFFFF_FFFF);
                        mon_t0 = cyc;
                    end else begin
                        chk("byte_gap", cyc, mon_t0 + 10 * CPB * mon_idx);
                    end
                end

                if (bus.i_valid && cyc >= free_at) begin
                    push_frame(bus.i_dieRoll);
                    exp_start_q.push_back(cyc + 1);
                    done_at  = cyc + FRAME_CYC + 1;
                    free_at  = cyc + FRAME_CYC + 2;
                    last_acc = cyc;
                    n_acc++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (cyc < free_at && n < 1000) begin
            tick();
            n++;
        end
        chk("wait_ready", {31'd0, n < 1000}, 32'd1);
    endtask

    task automatic send(input logic [4:0] roll);
        wait_ready();
        bus.i_valid   = 1'b1;
        bus.i_dieRoll = roll;
        tick();
        bus.i_valid   = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((cyc < free_at || exp_q.size() > 0 || mon_act) && n < 2000) begin
            tick();
            n++;
        end
        chk("wait_idle", {31'd0, n < 2000}, 32'd1);
    endtask

    initial begin : stim
        int target;
        int a0;
        int n;
        bus.i_valid   = 1'b0;
        bus.i_dieRoll = 5'd0;

        #12;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_ready", {31'd0, bus.o_ready}, 32'd1);
        chk("rst_done", {31'd0, bus.o_done}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        send(5'd0);
        wait_idle();
        send(5'd19);
        wait_idle();
        send(5'd31);
        wait_idle();

        // Requests during a frame are dropped.
        send(5'd5);
        for (int k = 1; k <= 100; k++) begin
            bus.i_valid   = (k == 10 || k == 100);
            bus.i_dieRoll = 5'd9;
            tick();
        end
        bus.i_valid = 1'b0;
        wait_idle();

        send(5'd11);
        for (int k = 0; k < 170; k++) begin
            bus.i_dieRoll = 5'($urandom());
            tick();
        end
        wait_idle();

        // Reset in the middle of byte1's data bits.
        send(5'($urandom_range(0, 31)));
        target = last_acc + 1 + 10 * CPB + 4 * CPB;
        while (cyc < target) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        chk("midrst_ready", {31'd0, bus.o_ready}, 32'd1);
        chk("midrst_done", {31'd0, bus.o_done}, 32'd0);
        tick();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send(5'($urandom_range(0, 31)));
        wait_idle();

        // Back-to-back frames with i_valid held high.
        a0 = n_acc;
        bus.i_valid   = 1'b1;
        bus.i_dieRoll = 5'd3;
        n = 0;
        while (n_acc < a0 + 2 && n < 1000) begin
            tick();
            n++;
        end
        bus.i_valid = 1'b0;
        chk("hold_accepts", n_acc, a0 + 2);
        wait_idle();

        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 4)) tick();
            send(5'($urandom_range(0, 31)));
            for (int k = 0; k < 20; k++) begin
                bus.i_valid   = 1'($urandom_range(0, 1));
                bus.i_dieRoll = 5'($urandom());
                tick();
            end
            bus.i_valid = 1'b0;
        end
        wait_idle();
        tick();

        chk("bytes_left", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
